// File: rtl/div_share_ctrl_if.sv
// div_share_ctrl bus bundle: requester handshake, response
// and divider-side signals grouped for the controller.
interface div_share_ctrl_if #(
    parameter int NREQ = 4,
    parameter int DW   = 13,
    parameter int QW   = 12
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_dividend;
    logic [NREQ*DW-1:0] req_divisor;
    logic [NREQ-1:0]    rsp_valid;
    logic [QW-1:0]      rsp_quotient;
    logic               rsp_dz;
    logic               idle;
    logic               div_start;
    logic [DW-1:0]      div_dividend;
    logic [DW-1:0]      div_divisor;
    logic [QW-1:0]      div_quotient;

    modport master (
        input  req_valid, req_dividend, req_divisor, div_quotient,
        output req_ready, rsp_valid, rsp_quotient, rsp_dz, idle,
        output div_start, div_dividend, div_divisor
    );

    modport slave (
        output req_valid, req_dividend, req_divisor, div_quotient,
        input  req_ready, rsp_valid, rsp_quotient, rsp_dz, idle,
        input  div_start, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin sharing of one pipelined divider
// among NREQ requesters, with a tag line matching its latency.
module div_share_ctrl #(
    parameter int NREQ    = 4,
    parameter int DW      = 13,
    parameter int QW      = 12,
    parameter int DIV_LAT = 12
) (
    input  logic           clk,
    input  logic           rst,
    div_share_ctrl_if.master bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(DIV_LAT + 3);

    logic [IW-1:0]   r_ptr;
    logic [DIV_LAT:0] r_tv;
    logic [DIV_LAT:0] r_tdz;
    logic [IW-1:0]   r_tid [DIV_LAT+1];
    logic [NREQ-1:0] r_rsp_valid;
    logic [QW-1:0]   r_rsp_q;
    logic            r_rsp_dz;
    logic            r_start;
    logic [DW-1:0]   r_dd;
    logic [DW-1:0]   r_dv;
    logic [CW-1:0]   r_cnt;

    logic            w_hs;
    logic [IW-1:0]   w_gid;
    logic [IW-1:0]   w_idx;
    logic [NREQ-1:0] w_grant;
    logic [DW-1:0]   w_dd;
    logic [DW-1:0]   w_dv;
    logic            w_rsp;
    logic            w_rsp_out;

    // Round-robin search starting at the pointer; no grant in reset.
    always_comb begin
        w_hs  = 1'b0;
        w_gid = '0;
        w_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IW'((int'(r_ptr) + k) % NREQ);
            if (!w_hs && bus.req_valid[w_idx]) begin
                w_hs  = 1'b1;
                w_gid = w_idx;
            end
        end
        if (rst) begin
            w_hs = 1'b0;
        end
    end

    assign w_grant   = w_hs ? (NREQ'(1) << w_gid) : '0;
    assign w_dd      = bus.req_dividend[w_gid*DW +: DW];
    assign w_dv      = bus.req_divisor[w_gid*DW +: DW];
    assign w_rsp     = r_tv[DIV_LAT];
    assign w_rsp_out = |r_rsp_valid;

    assign bus.req_ready    = w_grant;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_quotient = r_rsp_q;
    assign bus.rsp_dz       = r_rsp_dz;
    assign bus.idle         = (r_cnt == '0);
    assign bus.div_start    = r_start;
    assign bus.div_dividend = r_dd;
    assign bus.div_divisor  = r_dv;

    // Requester ids ride alongside the valid bits; no reset needed
    // since a slot is only consumed when its valid bit is set.
    always_ff @(posedge clk) begin
        r_tid[0] <= w_gid;
        for (int k = 1; k <= DIV_LAT; k++) begin
            r_tid[k] <= r_tid[k-1];
        end
    end

    // Issue, tag shifting, response steering and in-flight count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_tv        <= '0;
            r_tdz       <= '0;
            r_rsp_valid <= '0;
            r_rsp_q     <= '0;
            r_rsp_dz    <= 1'b0;
            r_start     <= 1'b0;
            r_dd        <= '0;
            r_dv        <= '0;
            r_cnt       <= '0;
        end else begin
            r_start <= 1'b1;
            if (w_hs) begin
                r_dd  <= w_dd;
                r_dv  <= w_dv;
                r_ptr <= (w_gid == IW'(NREQ - 1)) ? '0 : w_gid + 1'b1;
            end
            r_tv  <= {r_tv[DIV_LAT-1:0], w_hs};
            r_tdz <= {r_tdz[DIV_LAT-1:0], w_hs & (w_dv == '0)};
            if (w_rsp) begin
                r_rsp_valid <= NREQ'(1) << r_tid[DIV_LAT];
                r_rsp_q     <= r_tdz[DIV_LAT] ? '1 : bus.div_quotient;
                r_rsp_dz    <= r_tdz[DIV_LAT];
            end else begin
                r_rsp_valid <= '0;
                r_rsp_dz    <= 1'b0;
            end
            case ({w_hs, w_rsp_out})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: directed bench for div_share_ctrl with a
// delay-line divider stub returning {dividend[5:0], divisor[5:0]}.
module tb_div_share_ctrl;
    localparam int LAT = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc_n = 0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    bit   push_en = 1'b1;

    typedef struct {
        int         due;
        int         id;
        logic [11:0] q;
        logic       dz;
    } exp_t;
    exp_t eq[$];

    logic [12:0] dd [4];
    logic [12:0] dv [4];
    logic [11:0] pipe [LAT];

    div_share_ctrl_if #(.NREQ(4), .DW(13), .QW(12)) bus ();

    div_share_ctrl #(.NREQ(4), .DW(13), .QW(12), .DIV_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Cycle number, updated at every rising edge.
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Divider stub: LAT-stage delay line advanced by div_start.
    always @(posedge clk) begin
        if (bus.div_start) begin
            pipe[0] <= {bus.div_dividend[5:0], bus.div_divisor[5:0]};
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
    end
    assign bus.div_quotient = pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     tag, act, exp, cyc_n);
        end
    endtask

    function automatic logic [11:0] stubq(input logic [12:0] a,
                                          input logic [12:0] b);
        return {a[5:0], b[5:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input int i, input logic [12:0] a,
                      input logic [12:0] b);
        dd[i] = a;
        dv[i] = b;
        bus.req_dividend[i*13 +: 13] = a;
        bus.req_divisor[i*13 +: 13]  = b;
    endtask

    // One request cycle: check the grant, record the expected response.
    task automatic req_cycle(input logic [3:0] v, input int exp_g,
                             input logic [11:0] q, input logic dz);
        exp_t e;
        bus.req_valid = v;
        #1;
        chk("grant", bus.req_ready, (exp_g < 0) ? 0 : (1 << exp_g));
        if (exp_g >= 0 && push_en) begin
            e.due = cyc_n + LAT + 2;
            e.id  = exp_g;
            e.q   = q;
            e.dz  = dz;
            eq.push_back(e);
        end
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && !bus.idle; i++) tick();
        chk("drain_idle", bus.idle, 1);
        tick();
    endtask

    // Response monitor: every cycle compares against the expected queue.
    initial begin
        exp_t e;
        logic [3:0] ev;
        forever begin
            @(posedge clk);
            #3;
            if (mon_en) begin
                ev = '0;
                if (eq.size() > 0 && eq[0].due == cyc_n) begin
                    e  = eq.pop_front();
                    ev = 4'(1 << e.id);
                    chk("rsp_quotient", bus.rsp_quotient, e.q);
                    chk("rsp_dz", bus.rsp_dz, e.dz);
                end else begin
                    chk("rsp_dz_idle", bus.rsp_dz, 0);
                end
                chk("rsp_valid", bus.rsp_valid, ev);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc_n);
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid    = 4'hF;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        for (int i = 0; i < 4; i++) op(i, 13'h0, 13'h1);

        // Reset values, with all requests raised during reset.
        repeat (3) tick();
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_q", bus.rsp_quotient, 0);
        chk("rst_rsp_dz", bus.rsp_dz, 0);
        chk("rst_start", bus.div_start, 0);
        chk("rst_dd", bus.div_dividend, 0);
        chk("rst_dv", bus.div_divisor, 0);
        chk("rst_idle", bus.idle, 1);
        bus.req_valid = '0;
        rst = 1'b0;
        mon_en = 1'b1;
        tick();
        chk("start_on", bus.div_start, 1);

        // Single op from requester 2.
        op(2, 13'h015, 13'h007);
        req_cycle(4'b0100, 2, 12'h547, 1'b0);
        bus.req_valid = '0;
        chk("div_dd", bus.div_dividend, 13'h015);
        chk("div_dv", bus.div_divisor, 13'h007);
        for (int k = 1; k <= 14; k++) begin
            chk("busy", bus.idle, 0);
            tick();
        end
        chk("idle_after", bus.idle, 1);
        drain();

        // Contention straight out of reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        op(0, 13'h0031, 13'h0002);
        op(1, 13'h1FFF, 13'h0015);
        op(2, 13'h0008, 13'h003F);
        op(3, 13'h0A00, 13'h0001);
        for (int g = 0; g < 8; g++) begin
            req_cycle(4'hF, g % 4, stubq(dd[g%4], dv[g%4]), 1'b0);
        end
        bus.req_valid = '0;
        drain();

        // Zero divisor then normal op, requester 1.
        op(1, 13'h0A5, 13'h000);
        req_cycle(4'b0010, 1, 12'hFFF, 1'b1);
        op(1, 13'h0A5, 13'h003);
        req_cycle(4'b0010, 1, 12'h943, 1'b0);
        bus.req_valid = '0;
        drain();

        // Pointer wrap: 3 alone, then 0 and 3 together.
        op(3, 13'h012, 13'h004);
        op(0, 13'h03C, 13'h011);
        req_cycle(4'b1000, 3, 12'h484, 1'b0);
        req_cycle(4'b1001, 0, 12'hF11, 1'b0);
        bus.req_valid = '0;
        drain();

        // Withdrawn request: 0 drops while 1 is granted.
        op(1, 13'h007, 13'h009);
        req_cycle(4'b0011, 1, 12'h1C9, 1'b0);
        req_cycle(4'b0000, -1, 12'h000, 1'b0);
        drain();

        // Reset mid-flight: aborted ops must never respond.
        push_en = 1'b0;
        req_cycle(4'hF, 2, 12'h0, 1'b0);
        req_cycle(4'hF, 3, 12'h0, 1'b0);
        req_cycle(4'hF, 0, 12'h0, 1'b0);
        req_cycle(4'hF, 1, 12'h0, 1'b0);
        req_cycle(4'hF, 2, 12'h0, 1'b0);
        bus.req_valid = '0;
        tick();
        rst = 1'b1;
        bus.req_valid = 4'hF;
        tick();
        chk("mid_idle", bus.idle, 1);
        chk("mid_start", bus.div_start, 0);
        chk("mid_ready", bus.req_ready, 0);
        rst = 1'b0;
        push_en = 1'b1;
        op(0, 13'h005, 13'h00A);
        req_cycle(4'hF, 0, 12'h14A, 1'b0);
        bus.req_valid = '0;
        chk("post_start", bus.div_start, 1);
        chk("post_busy", bus.idle, 0);
        drain();
        repeat (20) tick();
        chk("pending", eq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/div_share_ctrl.md
# div_share_ctrl

Round-robin controller that shares one fixed-latency pipelined 13-bit divider among NREQ requesters. It accepts at most one request per cycle and registers the operands into the divider. Each in-flight operation is tracked by a tag delay line aligned to the divider latency. The quotient is steered back to the issuing requester, with divide-by-zero flagged. The block sits between the client blocks and the divider instance; clients never drive the divider directly.

## Interface
- NREQ, 4: number of requesters (2..8).
- DW, 13: operand width.
- QW, 12: quotient width.
- DIV_LAT, 12: cycles from operands valid at the divider inputs to the matching quotient at `div_quotient`.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant.
  - Combinational from `req_valid` and the round-robin pointer.
  - Handshake when `req_valid[i] & req_ready[i]`.
- req_dividend  in  NREQ*DW  packed; slice i is `[i*DW +: DW]`.
- req_divisor  in  NREQ*DW  packed, same layout.
- rsp_valid  out  NREQ  one-cycle registered pulse to the issuing requester; no backpressure.
- rsp_quotient  out  QW  result; valid only with a `rsp_valid` bit set.
- rsp_dz  out  1  divide-by-zero flag qualifying `rsp_valid`.
- idle  out  1  high when no operation is in flight and no response is pending.
- div_start  out  1  divider pipeline enable (registered).
- div_dividend  out  DW  registered operand to the divider.
- div_divisor  out  DW  registered operand to the divider.
- div_quotient  in  QW  divider result.

## Operation
- **Divider enable.** `div_start` is 0 during reset and 1 from the first cycle after `rst` deasserts. The divider pipeline therefore advances every cycle.
- **Bubbles.** In cycles with no grant, `div_dividend`/`div_divisor` hold their previous value. The tag for that slot is invalid.
- **Arbitration.**
  - Pointer `ptr` (reset 0). The grant goes to the first i with `req_valid[i]`, searching ptr, ptr+1, … mod NREQ.
  - After a handshake by requester g, `ptr` becomes (g+1) mod NREQ. With no handshake, `ptr` holds.
  - `req_ready` is all-zero during `rst`.
- **Issue.**
  - On a handshake, `div_dividend`/`div_divisor` register the granted operands.
  - A tag {valid=1, id=g, dz=(divisor==0)} enters stage 0 of a DIV_LAT+1 deep tag shift register. Any other cycle pushes valid=0.
- **Zero divisor.** Zero-divisor operations are still issued to the divider, which keeps per-requester ordering.
- **Response.** When the tag leaving the last stage is valid:
  - `rsp_valid[id]` pulses for one cycle.
  - `rsp_quotient` = `div_quotient`, or all-ones if dz.
  - `rsp_dz` = dz.
- **Response defaults.** In cycles without a response, `rsp_quotient` holds its last value and `rsp_dz` = 0.
- **In-flight count.** An in-flight counter (0..DIV_LAT+2) increments on handshake and decrements on response. A simultaneous handshake and response leaves it unchanged. `idle` = (count==0).
- **Ordering.** Results return strictly in issue order, both globally and per requester.
- **Arithmetic.** `div_quotient` is passed through unmodified; the controller does no range checking.

## Timing
- **Reset values:**
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_quotient` = 0, `rsp_dz` = 0.
  - `div_start` = 0, `div_dividend` = 0, `div_divisor` = 0.
  - `idle` = 1, `ptr` = 0, all tags invalid.
- **Latency.** Handshake in cycle T → operands at the divider in T+1 → quotient at `div_quotient` in T+1+DIV_LAT → `rsp_valid` in T+2+DIV_LAT. That is cycle T+14 at the defaults.
- **Throughput.** One operation per cycle sustained, with no gaps required between grants.
- **Fairness.** With all NREQ requesting continuously, each requester is granted exactly once per NREQ cycles.
- **Held request.** A requester that drops `req_valid` before a handshake loses nothing. A request held high is granted within NREQ cycles.
- **Reset mid-operation.**
  - All tags clear and the counter returns to 0.
  - No `rsp_valid` is produced for operations issued before reset, even if `div_quotient` is still changing.
- **Reset timing.** `rst` takes effect at the clock edge where it is sampled. The first handshake is possible in the cycle after deassertion.

## Test plan
The bench uses a divider stub: a DIV_LAT-stage delay line returning {dividend[5:0], divisor[5:0]}.
- **Single op.** Requester 2 issues dividend=0x015, divisor=0x007 in cycle T. Required: `rsp_valid`=4'b0100 only in T+14, `rsp_quotient`=0x547, `rsp_dz`=0; `idle` low T+1..T+14, high at T+15.
- **Contention.** All 4 requesters hold valid for 8 cycles from reset. Required: grants go 0,1,2,3,0,1,2,3, one per cycle; responses arrive in the same order 14 cycles after each grant.
- **Zero divisor.** Requester 1 issues divisor=0 followed by a normal op. Required: the first response has `rsp_quotient`=0xFFF and `rsp_dz`=1; the second has stub data and `rsp_dz`=0; they arrive in order on consecutive cycles.
- **Pointer hold.** Requester 3 issues alone, then requesters 0 and 3 request together. Required: the grant goes to 0 (ptr wrapped to 0 after the grant to 3).
- **Reset mid-flight.** Issue 5 back-to-back ops, then assert `rst` for 1 cycle at T+6. Required: no `rsp_valid` ever for those ops; `idle`=1 and `div_start`=0 during reset; normal operation from the cycle after reset.
- **Withdrawn request.** Requester 0 raises valid, then drops it while requester 1 is being granted. Required: no response ever goes to requester 0.
